// File: rtl/rsa_modexp_ctrl.sv
// rsa_modexp_ctrl: left-to-right square-and-multiply sequencer driving one shared Montgomery multiplier.
// Optional macro RSA_MODEXP_SKIP_LZ_EN: a one-cycle priority scan skips leading exponent zeros.
module rsa_modexp_ctrl #(
    parameter int WIDTH = 2048,
    parameter int LEN_W = 11,
    parameter int CNT_W = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] e,
    input  logic [LEN_W-1:0] e_len,
    input  logic [WIDTH-1:0] n,
    input  logic [WIDTH-1:0] r2,
    output logic [WIDTH-1:0] mul_a,
    output logic [WIDTH-1:0] mul_b,
    output logic [WIDTH-1:0] mul_n,
    output logic             mul_start,
    input  logic             mul_done,
    input  logic [WIDTH-1:0] mul_result,
    output logic             busy,
    output logic             finish,
    output logic [WIDTH-1:0] result,
    output logic [CNT_W-1:0] mul_count
);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [IDX_W:0]   LEN_ONE = (IDX_W+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_CONV_X, S_CONV_1, S_SCAN, S_SQUARE, S_MULT, S_CONV_OUT, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic             waiting_q;
    logic [WIDTH-1:0] x_q, e_q, r2_q, xm_q, acc_q;
    logic [IDX_W:0]   len_q, len_in;
    logic [IDX_W-1:0] idx_q;
    logic             accept, issue, capture, op_state, bit_set, idx_zero;
    logic [WIDTH-1:0] op_a, op_b;

    // Lengths beyond the operand width are clamped so the scan never indexes past e.
    assign len_in   = (int'(e_len) > WIDTH) ? (IDX_W+1)'(WIDTH) : (IDX_W+1)'(e_len);
    assign bit_set  = e_q[idx_q];
    assign idx_zero = (idx_q == '0);

`ifdef RSA_MODEXP_SKIP_LZ_EN
    logic             scan_found;
    logic [IDX_W-1:0] scan_idx;

    always_comb begin
        scan_found = 1'b0;
        scan_idx   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (e_q[i] && (i < int'(len_q))) begin
                scan_found = 1'b1;
                scan_idx   = IDX_W'(i);
            end
        end
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (accept) state_d = S_CONV_X;
            S_CONV_X:       if (capture) state_d = S_CONV_1;
`ifdef RSA_MODEXP_SKIP_LZ_EN
            S_CONV_1:       if (capture) state_d = S_SCAN;
            S_SCAN:         state_d = scan_found ? S_SQUARE : S_CONV_OUT;
`else
            S_CONV_1:       if (capture) state_d = (len_q == '0) ? S_CONV_OUT : S_SQUARE;
`endif
            S_SQUARE: if (capture) begin
                if (bit_set)       state_d = S_MULT;
                else if (idx_zero) state_d = S_CONV_OUT;
                else               state_d = S_SQUARE;
            end
            S_MULT:     if (capture) state_d = idx_zero ? S_CONV_OUT : S_SQUARE;
            S_CONV_OUT: if (capture) state_d = S_DONE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        op_state = 1'b0;
        op_a     = '0;
        op_b     = '0;
        busy     = 1'b1;
        finish   = 1'b0;
        case (state_q)
            S_IDLE:     busy = 1'b0;
            S_CONV_X:   begin op_state = 1'b1; op_a = x_q;   op_b = r2_q;  end
            S_CONV_1:   begin op_state = 1'b1; op_a = ONE;   op_b = r2_q;  end
            S_SQUARE:   begin op_state = 1'b1; op_a = acc_q; op_b = acc_q; end
            S_MULT:     begin op_state = 1'b1; op_a = acc_q; op_b = xm_q;  end
            S_CONV_OUT: begin op_state = 1'b1; op_a = acc_q; op_b = ONE;   end
            S_DONE:     begin busy = 1'b0; finish = 1'b1; end
            default:    ;
        endcase
        accept  = start && ((state_q == S_IDLE) || (state_q == S_DONE));
        issue   = op_state && !waiting_q;
        capture = op_state && waiting_q && mul_done;
    end

    // Operand registers only change on issue, so they hold steady while the multiplier runs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_a     <= '0;
            mul_b     <= '0;
            mul_n     <= '0;
            mul_start <= 1'b0;
            mul_count <= '0;
            result    <= '0;
            waiting_q <= 1'b0;
            x_q       <= '0;
            e_q       <= '0;
            r2_q      <= '0;
            xm_q      <= '0;
            acc_q     <= '0;
            len_q     <= '0;
            idx_q     <= '0;
        end else begin
            mul_start <= issue;
            if (accept) begin
                x_q       <= x;
                e_q       <= e;
                r2_q      <= r2;
                mul_n     <= n;
                len_q     <= len_in;
                mul_count <= '0;
            end
            if (issue) begin
                mul_a     <= op_a;
                mul_b     <= op_b;
                mul_count <= mul_count + CNT_W'(1);
                waiting_q <= 1'b1;
            end else if (capture) begin
                waiting_q <= 1'b0;
            end
            if (capture) begin
                case (state_q)
                    S_CONV_X:                   xm_q   <= mul_result;
                    S_CONV_1, S_SQUARE, S_MULT: acc_q  <= mul_result;
                    S_CONV_OUT:                 result <= mul_result;
                    default:                    ;
                endcase
            end
`ifdef RSA_MODEXP_SKIP_LZ_EN
            if (state_q == S_SCAN) idx_q <= scan_idx;
`else
            if (capture && state_q == S_CONV_1) idx_q <= IDX_W'(len_q - LEN_ONE);
`endif
            if (capture && !idx_zero &&
                ((state_q == S_SQUARE && !bit_set) || state_q == S_MULT))
                idx_q <= idx_q - IDX_W'(1);
        end
    end
endmodule

// File: tb/tb_rsa_modexp_ctrl.sv
// Bench for rsa_modexp_ctrl: behavioural Montgomery multiplier (R=2^16) plus a scoreboard of expected runs.
module tb_rsa_modexp_ctrl;
    localparam int WIDTH = 16;
    localparam int LEN_W = 11;
    localparam int CNT_W = 13;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] x, e, n, r2;
    logic [LEN_W-1:0] e_len;
    logic [WIDTH-1:0] mul_a, mul_b, mul_n, mul_result, result;
    logic             mul_start, mul_done, busy, finish;
    logic [CNT_W-1:0] mul_count;

    rsa_modexp_ctrl #(.WIDTH(WIDTH), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .x(x), .e(e), .e_len(e_len), .n(n), .r2(r2),
        .mul_a(mul_a), .mul_b(mul_b), .mul_n(mul_n), .mul_start(mul_start),
        .mul_done(mul_done), .mul_result(mul_result), .busy(busy), .finish(finish),
        .result(result), .mul_count(mul_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [WIDTH-1:0] res;
        int               cnt;
        logic [WIDTH-1:0] n;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [WIDTH-1:0] mont(input logic [WIDTH-1:0] a, b, m);
        longint t;
        t = longint'(a) * longint'(b);
        for (int i = 0; i < WIDTH; i++) begin
            if (t[0]) t = t + longint'(m);
            t = t >>> 1;
        end
        if (t >= longint'(m)) t = t - longint'(m);
        return WIDTH'(t);
    endfunction

    function automatic logic [WIDTH-1:0] calc_r2(input logic [WIDTH-1:0] m);
        longint big;
        big = longint'(1) <<< (2 * WIDTH);
        return WIDTH'(big % longint'(m));
    endfunction

    // Plain modular square-and-multiply over the scanned bits; no Montgomery arithmetic involved.
    function automatic exp_t model(input logic [WIDTH-1:0] xi, ei, ni, input int len);
        exp_t   r;
        longint acc;
        int     l, top;
        l     = (len > WIDTH) ? WIDTH : len;
        acc   = 1;
        r.cnt = 3;
        top   = l - 1;
`ifdef RSA_MODEXP_SKIP_LZ_EN
        top = -1;
        for (int i = 0; i < l; i++) if (ei[i]) top = i;
`endif
        for (int i = top; i >= 0; i--) begin
            acc = (acc * acc) % longint'(ni);
            r.cnt++;
            if (ei[i]) begin
                acc = (acc * longint'(xi)) % longint'(ni);
                r.cnt++;
            end
        end
        r.res = WIDTH'(acc % longint'(ni));
        r.n   = ni;
        return r;
    endfunction

    // Multiplier model: samples on negedge, answers after a fixed or random latency.
    int               lat = 5;
    bit               rand_lat = 1'b0;
    bit               pending = 1'b0;
    bit               stale = 1'b0;
    int               wait_cnt = 0;
    logic [WIDTH-1:0] a_cap, b_cap, n_cap;

    initial begin
        mul_done   = 1'b0;
        mul_result = '0;
        forever begin
            @(negedge clk);
            mul_done = 1'b0;
            if (rst === 1'b1) stale = 1'b1;
            if (pending) begin
                if (!stale) begin
                    check("stable_a", mul_a, a_cap);
                    check("stable_b", mul_b, b_cap);
                    check("start_one_cycle", mul_start, 1'b0);
                end
                if (wait_cnt == 0) begin
                    mul_done   = 1'b1;
                    mul_result = mont(a_cap, b_cap, n_cap);
                    pending    = 1'b0;
                end else begin
                    wait_cnt--;
                end
            end else if (mul_start === 1'b1) begin
                a_cap    = mul_a;
                b_cap    = mul_b;
                n_cap    = mul_n;
                pending  = 1'b1;
                stale    = 1'b0;
                wait_cnt = rand_lat ? int'($urandom_range(20, 1)) - 1 : lat - 1;
            end
        end
    end

    // Called on a negedge; returns on the following negedge with start low again.
    task automatic pulse_start(input logic [WIDTH-1:0] xi, ei, ni, input int len);
        x     = xi;
        e     = ei;
        n     = ni;
        r2    = calc_r2(ni);
        e_len = LEN_W'(len);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic launch(input logic [WIDTH-1:0] xi, ei, ni, input int len);
        sb.push_back(model(xi, ei, ni, len));
        pulse_start(xi, ei, ni, len);
    endtask

    task automatic wait_finish(input string tag);
        exp_t ex;
        int   k;
        logic last_busy;
        k = 0;
        last_busy = busy;
        while (finish !== 1'b1 && k < 3000) begin
            last_busy = busy;
            @(negedge clk);
            k++;
        end
        if (finish !== 1'b1) begin
            check({tag, "_timeout"}, finish, 1'b1);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        if (sb.size() == 0) begin
            check({tag, "_unexpected_finish"}, 1'b1, 1'b0);
            return;
        end
        ex = sb.pop_front();
        check({tag, "_result"}, result, ex.res);
        check({tag, "_mul_count"}, mul_count, ex.cnt);
        check({tag, "_mul_n"}, mul_n, ex.n);
        check({tag, "_busy_low_at_finish"}, busy, 1'b0);
        check({tag, "_busy_high_before"}, last_busy, 1'b1);
    endtask

    task automatic wait_count(input int target, input string tag);
        int k;
        k = 0;
        while (mul_count !== CNT_W'(target) && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_reach_count"}, mul_count, target);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_result"}, result, 0);
        check({tag, "_mul_count"}, mul_count, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_finish"}, finish, 0);
        check({tag, "_mul_start"}, mul_start, 0);
        check({tag, "_mul_a"}, mul_a, 0);
        check({tag, "_mul_b"}, mul_b, 0);
        check({tag, "_mul_n"}, mul_n, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; x = '0; e = '0; n = '0; r2 = '0; e_len = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // 1: e_len=3 scans 101
        launch(16'd4, 16'd5, 16'd13, 3);
        wait_finish("t1");
        // 2: two leading zeros
        launch(16'd4, 16'd5, 16'd13, 5);
        wait_finish("t2");
        // 3: empty scan and all-zero exponent
        launch(16'd7, 16'd5, 16'd13, 0);
        wait_finish("t3_len0");
        launch(16'd7, 16'd0, 16'd13, 4);
        wait_finish("t3_e0");
        // clamp and a wide modulus
        launch(16'd9, 16'hA5C3, 16'd13, 20);
        wait_finish("clamp");
        launch(16'd12345, 16'hBEEF, 16'hFFF1, 16);
        wait_finish("wide");

        // 4: start during SQUARE ignored, then restart from DONE
        launch(16'd4, 16'd5, 16'd13, 5);
        wait_count(3, "t4_square");
        pulse_start(16'd3, 16'd7, 16'd11, 3);
        wait_finish("t4_ignored");
        launch(16'd5, 16'd11, 16'd13, 4);
        check("t4_finish_drop", finish, 1'b0);
        check("t4_busy_rise", busy, 1'b1);
        wait_finish("t4_restart");

        // 5: reset during MULT, late mul_done ignored
        pulse_start(16'd4, 16'd5, 16'd13, 3);
        wait_count(4, "t5_mult");
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero("t5_async");
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (10) @(negedge clk);
        check("t5_after_busy", busy, 1'b0);
        check("t5_after_finish", finish, 1'b0);
        check("t5_after_count", mul_count, 0);
        check("t5_model_idle", pending, 1'b0);
        launch(16'd4, 16'd5, 16'd13, 3);
        wait_finish("t5_rerun");

        // 6: random multiplier latency
        rand_lat = 1'b1;
        launch(16'd11, 16'h00B7, 16'd13, 8);
        wait_finish("t6_a");
        launch(16'd321, 16'h1234, 16'd1001, 13);
        wait_finish("t6_b");
        rand_lat = 1'b0;

        check("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
